// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit and the ALU:
// FSM states, ALU op codes, opcodes and datapath select values.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // Which kind of ALU operation the current state asks the decoder for.
    typedef enum logic [1:0] {
        ALU_CLS_NONE   = 2'd0,
        ALU_CLS_ADD    = 2'd1,
        ALU_CLS_FUNCT  = 2'd2,
        ALU_CLS_BRANCH = 2'd3
    } alu_class_t;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b1010;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    function automatic logic [2:0] imm_src_for(input logic [6:0] opcode);
        logic [2:0] imm;
        imm = IMM_I;
        case (opcode)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control unit (master) and the datapath (slave):
// instruction fields/flags in, control strobes and selects out.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic [2:0] imm_src;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, imm_src,
               illegal, state
    );

    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, imm_src,
               illegal, state
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps the requested operation class plus funct fields onto an ALU code,
// and resolves the branch-taken condition from the ALU zero flag.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        is_rtype,
    input  logic        zero,
    output logic [3:0]  alu_control,
    output logic        branch_taken
);

    always_comb begin
        alu_control  = ALU_AND;
        branch_taken = 1'b0;
        case (alu_class)
            ALU_CLS_NONE: alu_control = ALU_AND;
            ALU_CLS_ADD:  alu_control = ALU_ADD;
            ALU_CLS_FUNCT: begin
                case (funct3)
                    // instr[30] on an I-type addi is immediate data, not SUB.
                    3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            ALU_CLS_BRANCH: begin
                case (funct3)
                    3'b000: begin alu_control = ALU_SUB;  branch_taken = zero;  end
                    3'b001: begin alu_control = ALU_SUB;  branch_taken = !zero; end
                    3'b100: begin alu_control = ALU_SLT;  branch_taken = !zero; end
                    3'b101: begin alu_control = ALU_SLT;  branch_taken = zero;  end
                    3'b110: begin alu_control = ALU_SLTU; branch_taken = !zero; end
                    3'b111: begin alu_control = ALU_SLTU; branch_taken = zero;  end
                    default: begin alu_control = ALU_AND; branch_taken = 1'b0;  end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing RV32I instructions through fetch/decode/execute/
// memory/writeback; stalls on the memory ready handshake.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_control_if.master  bus
);

    state_t     state_q;
    state_t     state_d;
    alu_class_t alu_class;
    logic       branch_taken;
    logic [3:0] alu_control;
    logic       is_rtype;

    logic       pc_write_raw;
    logic       mem_read_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;

    assign is_rtype = (bus.opcode == OP_RTYPE);

    alu_decoder u_alu_decoder (
        .alu_class    (alu_class),
        .funct3       (bus.funct3),
        .funct7b5     (bus.funct7b5),
        .is_rtype     (is_rtype),
        .zero         (bus.zero),
        .alu_control  (alu_control),
        .branch_taken (branch_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        pc_write_raw  = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_class     = ALU_CLS_NONE;
        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_a    = SRCA_PC;
                alu_src_b    = SRCB_FOUR;
                alu_class    = ALU_CLS_ADD;
                result_src   = RES_ALURESULT;
                if (bus.mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_class = ALU_CLS_ADD;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    // funct3 010/011 have no branch meaning in RV32I.
                    OP_BRANCH:         state_d = (bus.funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_class = ALU_CLS_ADD;
                state_d   = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_read_raw = 1'b1;
                adr_src      = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = RES_MEMDATA;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write_raw = 1'b1;
                adr_src       = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_class = ALU_CLS_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_class = ALU_CLS_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src    = RES_ALUOUT;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_RS2;
                alu_class    = ALU_CLS_BRANCH;
                result_src   = RES_ALUOUT;
                pc_write_raw = branch_taken;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                // Target was computed into ALUOut during DECODE; ALU now forms PC+4 for rd.
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                alu_class    = ALU_CLS_ADD;
                result_src   = RES_ALUOUT;
                pc_write_raw = 1'b1;
                state_d      = S_ALUWB;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    assign bus.pc_write    = rst_n & pc_write_raw;
    assign bus.mem_read    = rst_n & mem_read_raw;
    assign bus.mem_write   = rst_n & mem_write_raw;
    assign bus.ir_write    = rst_n & ir_write_raw;
    assign bus.reg_write   = rst_n & reg_write_raw;
    assign bus.adr_src     = adr_src;
    assign bus.result_src  = result_src;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.alu_control = alu_control;
    assign bus.imm_src     = imm_src_for(bus.opcode);
    assign bus.illegal     = (state_q == S_TRAP);
    assign bus.state       = state_q;

endmodule
